// File: rtl/encoder8to3_queue_if.sv
// Request/code bus of the sequential 8-to-3 encoder.
// The master side drives the request lines and consumer ready. The slave side is the encoder.
interface encoder8to3_queue_if;
    logic [7:0] d;
    logic       d_valid;
    logic       x;
    logic       y;
    logic       z;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;

    modport master (
        output d, d_valid, out_ready,
        input  x, y, z, out_valid, pending, overflow
    );

    modport slave (
        input  d, d_valid, out_ready,
        output x, y, z, out_valid, pending, overflow
    );
endinterface

// File: rtl/encoder8to3_queue.sv
// Sequential 8-to-3 encoder: merges request lines into a pending register and
// hands out one binary index per valid/ready transfer, in fixed priority order.
//
// state   | meaning
// IDLE    | nothing presented; waits for a pending request
// PRESENT | {x,y,z} holds a pending line's index, out_valid=1
module encoder8to3_queue #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    encoder8to3_queue_if.slave bus
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0] state_q, state_nx;
    logic [2:0] code_q, code_nx;
    logic [7:0] pending_q, pending_nx;
    logic [7:0] clr, set;
    logic       overflow_q, overflow_nx;
    logic       fire;

    function automatic logic [2:0] prio(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        // Later matches overwrite earlier ones, so scan direction sets priority.
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        fire        = (state_q == PRESENT) && bus.out_ready;
        clr         = fire ? (8'b1 << code_q) : 8'h00;
        set         = bus.d_valid ? bus.d : 8'h00;
        // A re-request of the line being granted survives as a fresh request.
        pending_nx  = (pending_q & ~clr) | set;
        overflow_nx = |(set & pending_q & ~clr);
        state_nx    = state_q;
        code_nx     = code_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 8'h00) begin
                    code_nx  = prio(pending_q);
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (fire) begin
                    if (pending_nx != 8'h00) begin
                        code_nx = prio(pending_nx);
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= 3'b000;
            pending_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_nx;
            code_q     <= code_nx;
            pending_q  <= pending_nx;
            overflow_q <= overflow_nx;
        end
    end

    assign {bus.x, bus.y, bus.z} = code_q;
    assign bus.out_valid         = (state_q == PRESENT);
    assign bus.pending           = pending_q;
    assign bus.overflow          = overflow_q;
endmodule
